// File: rtl/imm_field_packer.sv
// Packs a signed value into an (msb_num+1)-bit field, scanning one bit per cycle for overflow.
// Optional build macro IMM_PACK_SAT_EN: saturate the packed field when the value does not fit.
module imm_field_packer #(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WIDTH-1:0]         in,
  input  logic [$clog2(WIDTH)-1:0] msb_num,
  input  logic                     shift_last,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         out,
  output logic                     fits,
  output logic                     align_err
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] MAX_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state, state_n;
  logic [WIDTH-1:0] v;
  logic [IW-1:0]    msb_q;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    msb_next;
  logic             accept;
  logic [WIDTH-1:0] keep_mask;
  logic [WIDTH-1:0] packed_val;

  assign msb_next  = msb_q + IW'(1);
  assign keep_mask = {WIDTH{1'b1}} >> (MAX_IDX - msb_q);

`ifdef IMM_PACK_SAT_EN
  logic [WIDTH-1:0] sign_mask;
  logic [WIDTH-1:0] sat_val;

  // Saturate toward the sign of the original value: 0111.. or 1000.. within the field.
  assign sign_mask  = keep_mask ^ (keep_mask >> 1);
  assign sat_val    = v[WIDTH-1] ? sign_mask : (keep_mask >> 1);
  assign packed_val = fits ? (v & keep_mask) : sat_val;
`else
  assign packed_val = v & keep_mask;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = (msb_num < MAX_IDX) ? SCAN : DONE;
        end
      end
      SCAN:    if (idx == msb_next) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: v and msb_q are plain registers, not memories, so resetting them is cheap and keeps sim X-free.
      v         <= '0;
      msb_q     <= '0;
      idx       <= MAX_IDX;
      busy      <= 1'b0;
      done      <= 1'b0;
      out       <= '0;
      fits      <= 1'b0;
      align_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            v         <= shift_last ? {in[WIDTH-1], in[WIDTH-1:1]} : in;
            msb_q     <= msb_num;
            align_err <= shift_last & in[0];
            fits      <= 1'b1;
            idx       <= MAX_IDX;
            busy      <= 1'b1;
          end
        end
        SCAN: begin
          // Any bit above the field sign bit that disagrees with it means overflow.
          if (v[idx] != v[msb_q]) fits <= 1'b0;
          idx <= idx - IW'(1);
        end
        DONE: begin
          out  <= packed_val;
          done <= 1'b1;
          busy <= 1'b0;
          idx  <= MAX_IDX;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_field_packer.sv
// Self-checking bench for imm_field_packer (WIDTH=16), scoreboard of expected results per operation.
module tb_imm_field_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] in;
  logic [3:0]  msb_num;
  logic        shift_last;
  logic        busy;
  logic        done;
  logic [15:0] out;
  logic        fits;
  logic        align_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [15:0] out;
    logic        fits;
    logic        align;
    int          lat;
  } exp_t;

  exp_t sb[$];

  imm_field_packer #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in        (in),
    .msb_num   (msb_num),
    .shift_last(shift_last),
    .busy      (busy),
    .done      (done),
    .out       (out),
    .fits      (fits),
    .align_err (align_err)
  );

  always #5 clk = ~clk;

  // Reference from signed range arithmetic, independent of the bit scan.
  function automatic exp_t model(input logic [15:0] d, input int m, input logic sl);
    exp_t e;
    int   sv;
    int   word;
    sv = int'($signed(d));
    if (sl) sv = sv >>> 1;
    e.fits  = (sv >= -(1 << m)) && (sv <= (1 << m) - 1);
    word    = sv & ((1 << (m + 1)) - 1);
`ifdef IMM_PACK_SAT_EN
    if (!e.fits) word = (sv < 0) ? (1 << m) : ((1 << m) - 1);
`endif
    e.out   = word[15:0];
    e.align = sl & d[0];
    e.lat   = 16 - m;
    return e;
  endfunction

  task automatic run_op(input logic [15:0] d, input logic [3:0] m, input logic sl, input exp_t e);
    exp_t got;
    int   cnt;
    logic [15:0] out_q;
    sb.push_back(e);
    @(negedge clk);
    in = d; msb_num = m; shift_last = sl; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vec_cnt++;
    if (busy !== 1'b1) begin err_cnt++; $display("FAIL busy_after_accept: got %b want 1", busy); end
    cnt = 0;
    while (done !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    got = sb.pop_front();
    vec_cnt++;
    if (done !== 1'b1) begin
      err_cnt++;
      $display("FAIL done_timeout: in=%h msb=%0d no done after %0d cycles", d, m, cnt);
      return;
    end
    vec_cnt++;
    if (cnt != got.lat) begin err_cnt++; $display("FAIL latency in=%h msb=%0d: got %0d want %0d", d, m, cnt, got.lat); end
    vec_cnt++;
    if (out !== got.out) begin err_cnt++; $display("FAIL out in=%h msb=%0d sl=%b: got %h want %h", d, m, sl, out, got.out); end
    vec_cnt++;
    if (fits !== got.fits) begin err_cnt++; $display("FAIL fits in=%h msb=%0d sl=%b: got %b want %b", d, m, sl, fits, got.fits); end
    vec_cnt++;
    if (align_err !== got.align) begin err_cnt++; $display("FAIL align_err in=%h sl=%b: got %b want %b", d, sl, align_err, got.align); end
    vec_cnt++;
    if (busy !== 1'b0) begin err_cnt++; $display("FAIL busy_at_done: got %b want 0", busy); end
    out_q = out;
    @(negedge clk);
    vec_cnt++;
    if (done !== 1'b0 || out !== out_q || fits !== got.fits) begin
      err_cnt++;
      $display("FAIL hold_after_done: done=%b out=%h fits=%b want done=0 out=%h fits=%b", done, out, fits, out_q, got.fits);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in = '0; msb_num = '0; shift_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vec_cnt++;
    if ({busy, done, out, fits, align_err} !== 20'h0) begin
      err_cnt++;
      $display("FAIL reset_state: busy=%b done=%b out=%h fits=%b align=%b want all 0", busy, done, out, fits, align_err);
    end
  endtask

  task automatic test_spec_vectors();
    exp_t e;
    e = '{out: 16'h00F0, fits: 1'b1, align: 1'b0, lat: 9};
    run_op(16'hFFF0, 4'd7, 1'b0, e);
`ifdef IMM_PACK_SAT_EN
    e = '{out: 16'h007F, fits: 1'b0, align: 1'b0, lat: 9};
`else
    e = '{out: 16'h0000, fits: 1'b0, align: 1'b0, lat: 9};
`endif
    run_op(16'h0100, 4'd7, 1'b0, e);
`ifdef IMM_PACK_SAT_EN
    e = '{out: 16'h0080, fits: 1'b0, align: 1'b0, lat: 9};
`else
    e = '{out: 16'h0000, fits: 1'b0, align: 1'b0, lat: 9};
`endif
    run_op(16'hFF00, 4'd7, 1'b0, e);
    e = '{out: 16'h0003, fits: 1'b1, align: 1'b1, lat: 13};
    run_op(16'h0007, 4'd3, 1'b1, e);
    e = '{out: 16'h8000, fits: 1'b1, align: 1'b0, lat: 1};
    run_op(16'h8000, 4'd15, 1'b0, e);
  endtask

  task automatic test_random();
    logic [15:0] d;
    logic [3:0]  m;
    logic        sl;
    // Edge fields first (1-bit and full-width), then random ones.
    run_op(16'hFFFF, 4'd0, 1'b0, model(16'hFFFF, 0, 1'b0));
    run_op(16'h0001, 4'd0, 1'b0, model(16'h0001, 0, 1'b0));
    run_op(16'h8001, 4'd15, 1'b1, model(16'h8001, 15, 1'b1));
    for (int i = 0; i < 8; i++) begin
      d  = 16'($urandom);
      m  = 4'($urandom_range(0, 15));
      sl = 1'($urandom);
      if (i % 2 == 0) d = (d[15]) ? (d | 16'hFFC0) : (d & 16'h003F);
      run_op(d, m, sl, model(d, int'(m), sl));
    end
  endtask

  task automatic test_back_to_back();
    int dones;
    @(negedge clk);
    in = 16'h8000; msb_num = 4'd15; shift_last = 1'b0; start = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    start = 1'b0;
    vec_cnt++;
    if (dones != 4) begin err_cnt++; $display("FAIL held_start_dones: got %0d want 4", dones); end
    vec_cnt++;
    if (out !== 16'h8000 || fits !== 1'b1) begin
      err_cnt++;
      $display("FAIL held_start_result: out=%h fits=%b want 8000 1", out, fits);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int dones;
    @(negedge clk);
    in = 16'h1234; msb_num = 4'd3; shift_last = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vec_cnt++;
    if (busy !== 1'b0 || out !== 16'h0 || fits !== 1'b0 || done !== 1'b0) begin
      err_cnt++;
      $display("FAIL mid_scan_reset: busy=%b out=%h fits=%b done=%b want 0 0000 0 0", busy, out, fits, done);
    end
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    vec_cnt++;
    if (dones != 0) begin err_cnt++; $display("FAIL aborted_done: got %0d pulses want 0", dones); end
    // Reset wins over a simultaneous start.
    rst = 1'b1; start = 1'b1; in = 16'h0005; msb_num = 4'd15;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    vec_cnt++;
    if (dones != 0) begin err_cnt++; $display("FAIL reset_over_start: %0d busy/done cycles want 0", dones); end
    run_op(16'h1234, 4'd3, 1'b0, model(16'h1234, 3, 1'b0));
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
